// File: rtl/dual_issue_ctrl.sv
// -----------------------------------------------------------------------------
// dual_issue_ctrl
//
// Issue controller for the two-wide front end. Each cycle it inspects the
// fetched instruction pair (slot 1 = InstrF1, slot 2 = InstrF2). When the
// pair can issue together it lets both advance. Otherwise it splits the pair:
// slot 1 issues alone this cycle, and slot 2 issues alone in the following
// HOLD cycle while pipeline 1 is bubbled. It also counts dual-issue cycles
// and split decisions.
//
// Ports
//   clk               core clock, rising edge
//   rst               asynchronous active-low reset
//   en                global pipeline advance (low freezes state and counters)
//   flush             redirect from execute; cancels any pending split
//   InstrF1/InstrF2   slot-1 / slot-2 fetched instructions
//   StallPipeline2    comb: bubble pipeline 2 this cycle (fetch holds PCF2)
//   StallPipeline1NC  comb: pipeline 1 must stall in the next cycle
//   StallPipeline1    registered: pipeline 1 bubbled this cycle (HOLD)
//   SplitReason       comb: 00 none, 01 RAW, 10 memory, 11 control
//   DualCount         cycles that dual-issued
//   SplitCount        split decisions taken
// -----------------------------------------------------------------------------
module dual_issue_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [31:0]      InstrF1,
    input  logic [31:0]      InstrF2,
    output logic             StallPipeline2,
    output logic             StallPipeline1NC,
    output logic             StallPipeline1,
    output logic [1:0]       SplitReason,
    output logic [CNT_W-1:0] DualCount,
    output logic [CNT_W-1:0] SplitCount
);

    typedef enum logic {
        ST_DUAL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic reads_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_JALR) || (op == OP_JAL) || (op == OP_LUI) ||
               (op == OP_AUIPC);
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    // Only the fields the hazard check needs are decoded; the rest of the
    // instruction bits are deliberately ignored.
    logic [6:0] op1, op2;
    logic [4:0] rd1, rs1_2, rs2_2;
    logic       unused_bits;

    assign op1   = InstrF1[6:0];
    assign rd1   = InstrF1[11:7];
    assign op2   = InstrF2[6:0];
    assign rs1_2 = InstrF2[19:15];
    assign rs2_2 = InstrF2[24:20];
    assign unused_bits = ^{InstrF1[31:12], InstrF2[31:25], InstrF2[14:7]};

    // Hazard detection. x0 is never a real dependency.
    logic raw_hz, mem_hz, ctrl_hz, split;

    assign raw_hz  = writes_rd(op1) && (rd1 != 5'd0) &&
                     ((reads_rs1(op2) && (rs1_2 == rd1)) ||
                      (reads_rs2(op2) && (rs2_2 == rd1)));
    assign mem_hz  = is_mem(op1) && is_mem(op2);
    assign ctrl_hz = is_ctrl(op1);
    assign split   = raw_hz || mem_hz || ctrl_hz;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dual_cnt_q, dual_cnt_d;
    logic [CNT_W-1:0] split_cnt_q, split_cnt_d;

    always_comb begin
        state_d          = state_q;
        dual_cnt_d       = dual_cnt_q;
        split_cnt_d      = split_cnt_q;
        StallPipeline2   = 1'b0;
        StallPipeline1NC = 1'b0;
        SplitReason      = 2'b00;

        // Stall requests are only raised from DUAL and never during a flush;
        // they stay live while en is low so fetch sees a consistent view.
        if (state_q == ST_DUAL && !flush && split) begin
            StallPipeline2   = 1'b1;
            StallPipeline1NC = 1'b1;
            if (raw_hz)      SplitReason = 2'b01;
            else if (mem_hz) SplitReason = 2'b10;
            else             SplitReason = 2'b11;
        end

        if (flush) begin
            state_d = ST_DUAL;
        end else if (en) begin
            case (state_q)
                ST_DUAL: begin
                    if (split) begin
                        state_d     = ST_HOLD;
                        split_cnt_d = split_cnt_q + 1'b1;
                    end else begin
                        dual_cnt_d  = dual_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_DUAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_DUAL;
            dual_cnt_q  <= '0;
            split_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dual_cnt_q  <= dual_cnt_d;
            split_cnt_q <= split_cnt_d;
        end
    end

    // HOLD is encoded as 1, so the state flop itself is the registered stall.
    assign StallPipeline1 = (state_q == ST_HOLD);
    assign DualCount      = dual_cnt_q;
    assign SplitCount     = split_cnt_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
module tb_dual_issue_ctrl;

    localparam logic [31:0] I_ADD   = 32'h002082B3; // add x5,x1,x2
    localparam logic [31:0] I_LW    = 32'h0000A383; // lw  x7,0(x1)
    localparam logic [31:0] I_SUB   = 32'h40328333; // sub x6,x5,x3
    localparam logic [31:0] I_SW    = 32'h00312223; // sw  x3,4(x2)
    localparam logic [31:0] I_BEQ   = 32'h00208463; // beq x1,x2,8
    localparam logic [31:0] I_NOP   = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] I_ADDX0 = 32'h000002B3; // add x5,x0,x0

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        flush;
    logic [31:0] InstrF1, InstrF2;
    logic        StallPipeline2, StallPipeline1NC, StallPipeline1;
    logic [1:0]  SplitReason;
    logic [31:0] DualCount, SplitCount;

    int errors = 0;
    int checks = 0;

    dual_issue_ctrl #(.CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .flush            (flush),
        .InstrF1          (InstrF1),
        .InstrF2          (InstrF2),
        .StallPipeline2   (StallPipeline2),
        .StallPipeline1NC (StallPipeline1NC),
        .StallPipeline1   (StallPipeline1),
        .SplitReason      (SplitReason),
        .DualCount        (DualCount),
        .SplitCount       (SplitCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        flush;
        logic [31:0] i1;
        logic [31:0] i2;
        logic        s2;     // expected StallPipeline2 before the edge
        logic        nc;     // expected StallPipeline1NC before the edge
        logic [1:0]  rsn;    // expected SplitReason before the edge
        logic        s1;     // expected StallPipeline1 before the edge
        int          dcnt;   // expected DualCount after the edge
        int          scnt;   // expected SplitCount after the edge
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // One row per clock cycle, starting in DUAL with counters at zero.
        vecs[0]  = '{1, 0, I_ADD, I_LW,    0, 0, 2'b00, 0, 1, 0}; // dual issue
        vecs[1]  = '{1, 0, I_ADD, I_SUB,   1, 1, 2'b01, 0, 1, 1}; // RAW split
        vecs[2]  = '{1, 0, I_ADD, I_SUB,   0, 0, 2'b00, 1, 1, 1}; // HOLD
        vecs[3]  = '{1, 0, I_LW,  I_SW,    1, 1, 2'b10, 0, 1, 2}; // MEM split, back-to-back
        vecs[4]  = '{1, 0, I_LW,  I_SW,    0, 0, 2'b00, 1, 1, 2}; // HOLD
        vecs[5]  = '{1, 0, I_BEQ, I_ADD,   1, 1, 2'b11, 0, 1, 3}; // CTRL split
        vecs[6]  = '{1, 1, I_BEQ, I_ADD,   0, 0, 2'b00, 1, 1, 3}; // flush in HOLD
        vecs[7]  = '{1, 0, I_NOP, I_ADDX0, 0, 0, 2'b00, 0, 2, 3}; // x0 not a RAW
        vecs[8]  = '{0, 0, I_ADD, I_SUB,   1, 1, 2'b01, 0, 2, 3}; // en low x3
        vecs[9]  = '{0, 0, I_ADD, I_SUB,   1, 1, 2'b01, 0, 2, 3};
        vecs[10] = '{0, 0, I_ADD, I_SUB,   1, 1, 2'b01, 0, 2, 3};
        vecs[11] = '{1, 0, I_ADD, I_SUB,   1, 1, 2'b01, 0, 2, 4}; // split taken
        vecs[12] = '{0, 0, I_ADD, I_SUB,   0, 0, 2'b00, 1, 2, 4}; // en low in HOLD
        vecs[13] = '{1, 0, I_ADD, I_SUB,   0, 0, 2'b00, 1, 2, 4}; // HOLD completes
        vecs[14] = '{1, 1, I_ADD, I_SUB,   0, 0, 2'b00, 0, 2, 4}; // flush masks split
        vecs[15] = '{0, 1, I_LW,  I_SW,    0, 0, 2'b00, 0, 2, 4}; // flush with en low

        rst = 1'b0; en = 1'b0; flush = 1'b0; InstrF1 = I_NOP; InstrF2 = I_NOP;
        #12;
        chk("reset_s1",    {31'd0, StallPipeline1}, 32'd0);
        chk("reset_dual",  DualCount,  32'd0);
        chk("reset_split", SplitCount, 32'd0);
        chk("reset_s2",    {31'd0, StallPipeline2}, 32'd0);

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            en = vecs[i].en; flush = vecs[i].flush;
            InstrF1 = vecs[i].i1; InstrF2 = vecs[i].i2;
            #1;
            chk($sformatf("v%0d_s2", i),  {31'd0, StallPipeline2},   {31'd0, vecs[i].s2});
            chk($sformatf("v%0d_nc", i),  {31'd0, StallPipeline1NC}, {31'd0, vecs[i].nc});
            chk($sformatf("v%0d_rsn", i), {30'd0, SplitReason},      {30'd0, vecs[i].rsn});
            chk($sformatf("v%0d_s1", i),  {31'd0, StallPipeline1},   {31'd0, vecs[i].s1});
            @(posedge clk); #1;
            chk($sformatf("v%0d_dcnt", i), DualCount,  vecs[i].dcnt);
            chk($sformatf("v%0d_scnt", i), SplitCount, vecs[i].scnt);
            $display("vec %0d: en=%0b flush=%0b i1=%08h i2=%08h s2=%0b nc=%0b rsn=%0b s1=%0b dual=%0d split=%0d",
                     i, vecs[i].en, vecs[i].flush, vecs[i].i1, vecs[i].i2,
                     StallPipeline2, StallPipeline1NC, SplitReason, StallPipeline1,
                     DualCount, SplitCount);
            @(negedge clk);
        end

        // Asynchronous reset pulsed mid-HOLD.
        en = 1'b1; flush = 1'b0; InstrF1 = I_ADD; InstrF2 = I_SUB;
        @(posedge clk); #1;
        chk("hold_entered", {31'd0, StallPipeline1}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_s1",    {31'd0, StallPipeline1}, 32'd0);
        chk("arst_dual",  DualCount,  32'd0);
        chk("arst_split", SplitCount, 32'd0);
        // Back in DUAL, so the split pair is flagged again combinationally.
        chk("arst_s2",    {31'd0, StallPipeline2}, 32'd1);
        $display("arst: s1=%0b dual=%0d split=%0d s2=%0b",
                 StallPipeline1, DualCount, SplitCount, StallPipeline2);
        @(negedge clk);
        rst = 1'b1;
        InstrF1 = I_ADD; InstrF2 = I_LW;
        #1;
        chk("post_rst_s1", {31'd0, StallPipeline1}, 32'd0);
        @(posedge clk); #1;
        chk("post_rst_dual", DualCount,  32'd1);
        chk("post_rst_s1b",  {31'd0, StallPipeline1}, 32'd0);
        $display("post_rst: s1=%0b dual=%0d split=%0d",
                 StallPipeline1, DualCount, SplitCount);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dual_issue_ctrl.md
# dual_issue_ctrl

Issue controller for the two-wide superscalar front end. It examines the instruction pair fetched each cycle (slot 1 = InstrF1, slot 2 = InstrF2) and decides between dual issue and a two-cycle split: slot 1 alone, then slot 2 alone. It drives the fetch-stage stall controls StallPipeline2 and StallPipeline1NC, and sequences the hold cycle in which only pipeline 2 advances. It also keeps dual/split performance counters.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  core clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  global pipeline advance; low freezes state and counters
- flush  in  1  redirect from execute (either pipeline's PCSrc nonzero); kills the pending split
- InstrF1  in  32  slot-1 instruction from instruction memory
- InstrF2  in  32  slot-2 instruction from instruction memory
- StallPipeline2  out  1  bubble pipeline 2 this cycle; fetch holds PCF2
- StallPipeline1NC  out  1  pipeline 1 must stall in the next cycle
- StallPipeline1  out  1  registered; pipeline 1 bubbled this cycle (hold cycle)
- SplitReason  out  2  00 none, 01 RAW, 10 memory, 11 control; valid when StallPipeline2=1
- DualCount  out  CNT_W  cycles that dual-issued
- SplitCount  out  CNT_W  split decisions taken

## Operation
- Decode uses opcode [6:0], rd [11:7], rs1 [19:15] and rs2 [24:20].
- Reads rs1: opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
- Reads rs2: opcodes 0110011, 0100011, 1100011.
- Writes rd: opcodes 0110011, 0010011, 0000011, 1100111, 1101111, 0110111, 0010111.
- Memory op: opcodes 0000011, 0100011.
- Control op: opcodes 1100011, 1101111, 1100111.
- RAW hazard: slot 1 writes rd, rd≠0, and slot 2 reads rs1 or rs2 equal to that rd.
- MEM hazard: both slots are memory ops (single data port).
- CTRL hazard: slot 1 is a control op.
- Split = RAW | MEM | CTRL. SplitReason priority is RAW > MEM > CTRL.
- FSM has 2 states, DUAL and HOLD.
- DUAL, no split: both slots issue, all stall outputs 0, and the state stays DUAL.
- DUAL, split: StallPipeline2=1 and StallPipeline1NC=1, and the state goes to HOLD.
- HOLD: StallPipeline1=1, the stall-request outputs are 0, and there is no hazard evaluation. The held InstrF2 issues in pipeline 2, and the state goes to DUAL.
- flush=1 (overrides en):
  - StallPipeline2, StallPipeline1NC and SplitReason are forced to 0 combinationally.
  - The next state is DUAL.
  - Counters do not change.
- en=0, flush=0: state and counters hold. Combinational outputs still reflect the current instructions.
- Counters:
  - DualCount increments in a DUAL cycle with en=1, flush=0 and no split.
  - SplitCount increments in a DUAL cycle with en=1, flush=0 and a split.
  - Both wrap modulo 2^CNT_W.

## Timing
- Reset (rst=0, asynchronous) sets state to DUAL, StallPipeline1=0, DualCount=0 and SplitCount=0. Combinational outputs follow from the state.
- Reset deasserted mid-split: the controller is in DUAL on the first cycle after release, and no HOLD cycle occurs.
- StallPipeline2, StallPipeline1NC and SplitReason are combinational from InstrF1/InstrF2, state and flush, in the same cycle.
- StallPipeline1 is registered. It goes high exactly one cycle after a split cycle with en=1 and flush=0, for exactly one cycle.
- A split costs exactly 1 extra cycle. Back-to-back splits are allowed (DUAL→HOLD→DUAL→HOLD).
- en low during HOLD: the controller stays in HOLD and StallPipeline1 stays 1 until the en-high cycle completes it.
- flush during HOLD: the next state is DUAL, and StallPipeline1 is 0 the following cycle.

## Test plan
- Release reset, then present InstrF1=0x002082B3 (add x5,x1,x2) and InstrF2=0x0000A383 (lw x7,0(x1)).
  - Required: stalls 0, SplitReason=00, DualCount=1 after the edge.
- Present InstrF1=0x002082B3 and InstrF2=0x40328333 (sub x6,x5,x3).
  - Split cycle: StallPipeline2=1, StallPipeline1NC=1, SplitReason=01.
  - Next cycle: StallPipeline1=1.
  - The cycle after: back in DUAL, SplitCount=1.
- Present InstrF1=0x0000A383 (lw) and InstrF2=0x00312223 (sw x3,4(x2)).
  - Required: SplitReason=10 and a split.
- Present InstrF1=0x00208463 (beq), then assert flush in the following HOLD cycle.
  - Split cycle: SplitReason=11.
  - After the flush: StallPipeline1=0 and state DUAL, with no extra counter change.
- Present InstrF1=0x00000013 (addi x0,x0,0) and InstrF2=0x000002B3 (add x5,x0,x0).
  - Required: no RAW on x0, so dual issue.
- Two further scenarios:
  - Hold en=0 for 3 cycles with a split pair present. Required: state and counters unchanged.
  - Pulse rst low while in HOLD. Required: StallPipeline1=0 and counters 0 immediately, without waiting for a clock edge.
